// File: rtl/z80_rel_branch_seq.sv
// z80_rel_branch_seq
// Multi-cycle sequencer for the Z80 relative branches JR e, JR cc,e and DJNZ e.
// It is entered once M1 has fetched the opcode. It fetches the displacement
// byte over a request/acknowledge read, then resolves the branch condition.
// A taken branch spends the internal M-cycle before completion is reported.
// Every output is gated by the FSM state. The datapath latches therefore need
// no reset and still show their reset values whenever they are not valid.
// mcycle_type encoding: 0 = CYCLE_NONE, 1 = CYCLE_INTERNAL, 2 = CYCLE_RDWR_MEM.
module z80_rel_branch_seq #(
    parameter int ADDR_W     = 16,
    parameter bit EN_DJNZ    = 1'b1,
    parameter int INTERNAL_T = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        opcode,
    input  logic [ADDR_W-1:0] ip_in,
    input  logic [7:0]        f_in,
    input  logic [7:0]        b_in,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ip_out,
    output logic              taken,
    output logic              b_we,
    output logic [7:0]        b_out,
    output logic              illegal,
    output logic [2:0]        mcycle_type
);

    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd1;
    localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;

    localparam int              CNT_W    = (INTERNAL_T > 1) ? $clog2(INTERNAL_T) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERNAL_T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DJNZ_T,
        S_READ,
        S_INTERNAL,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] int_cnt, int_cnt_nx;

    // Values sampled with start
    logic [ADDR_W-1:0] ip_p0;
    logic [7:0]        b_p0;
    logic              cond_p0;
    logic              is_djnz_p0;
    logic              illegal_p0;

    // Values produced by the DJNZ decrement and the displacement read
    logic [7:0]        b_dec_p1;
    logic              taken_p1;
    logic [ADDR_W-1:0] ip_res_p1;

    logic dec_jr, dec_jrcc, dec_djnz, dec_legal;
    logic taken_now;

    // JR e is unconditional. JR cc,e tests Z (bit 6) or C (bit 0), selected by opcode[4:3].
    function automatic logic cond_met(input logic [7:0] op, input logic [7:0] f);
        logic res;
        if (op == 8'h18) begin
            res = 1'b1;
        end else begin
            case (op[4:3])
                2'b00:   res = ~f[6];
                2'b01:   res =  f[6];
                2'b10:   res = ~f[0];
                default: res =  f[0];
            endcase
        end
        return res;
    endfunction

    // Target is relative to the byte after the displacement: ip + 2 + sext(e), modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] ip,
                                                        input logic signed [7:0] e);
        logic [ADDR_W-1:0] e_ext;
        e_ext = {{(ADDR_W-8){e[7]}}, e};
        return ip + ADDR_W'(2) + e_ext;
    endfunction

    assign dec_jr    = (opcode == 8'h18);
    assign dec_jrcc  = (opcode == 8'h20) || (opcode == 8'h28) ||
                       (opcode == 8'h30) || (opcode == 8'h38);
    assign dec_djnz  = EN_DJNZ && (opcode == 8'h10);
    assign dec_legal = dec_jr || dec_jrcc || dec_djnz;

    assign taken_now = is_djnz_p0 ? (b_dec_p1 != 8'h00) : cond_p0;

    // State register and internal-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            int_cnt <= '0;
        end else begin
            state   <= state_nx;
            int_cnt <= int_cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx   = state;
        int_cnt_nx = int_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!dec_legal)    state_nx = S_DONE;
                    else if (dec_djnz) state_nx = S_DJNZ_T;
                    else               state_nx = S_READ;
                end
            end
            S_DJNZ_T: state_nx = S_READ;
            S_READ: begin
                if (rd_ack) begin
                    if (taken_now) begin
                        state_nx   = S_INTERNAL;
                        int_cnt_nx = '0;
                    end else begin
                        state_nx   = S_DONE;
                    end
                end
            end
            S_INTERNAL: begin
                if (int_cnt == CNT_LAST) state_nx = S_DONE;
                else                     int_cnt_nx = int_cnt + 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Stage 0: capture opcode context at start
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            ip_p0      <= ip_in;
            b_p0       <= b_in;
            cond_p0    <= cond_met(opcode, f_in);
            is_djnz_p0 <= dec_djnz;
            illegal_p0 <= ~dec_legal;
            taken_p1   <= 1'b0;
            ip_res_p1  <= ip_in + ADDR_W'(1);
        end
        // Stage 1: DJNZ decrement, then branch resolution on the read acknowledge
        if (state == S_DJNZ_T) begin
            b_dec_p1 <= b_p0 - 8'd1;
        end
        if (state == S_READ && rd_ack) begin
            taken_p1  <= taken_now;
            ip_res_p1 <= taken_now ? branch_target(ip_p0, rd_data) : ip_p0 + ADDR_W'(2);
        end
    end

    // State-decoded outputs; data outputs read as zero outside their valid window
    always_comb begin
        rd_req      = (state == S_READ);
        rd_addr     = (state == S_READ) ? ip_p0 + ADDR_W'(1) : '0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        ip_out      = (state == S_DONE) ? ip_res_p1 : '0;
        taken       = (state == S_DONE) && taken_p1;
        b_we        = (state == S_DONE) && is_djnz_p0;
        b_out       = ((state == S_DONE) && is_djnz_p0) ? b_dec_p1 : 8'h00;
        illegal     = (state == S_DONE) && illegal_p0;
        mcycle_type = CYCLE_NONE;
        case (state)
            S_DJNZ_T, S_INTERNAL: mcycle_type = CYCLE_INTERNAL;
            S_READ:               mcycle_type = CYCLE_RDWR_MEM;
            default:              mcycle_type = CYCLE_NONE;
        endcase
    end

endmodule

// File: tb/tb_z80_rel_branch_seq.sv
// Directed bench for z80_rel_branch_seq. It covers JR, JR cc, DJNZ, illegal
// opcodes, read wait states, start pulses while busy, asynchronous reset and
// the EN_DJNZ=0 build.
module tb_z80_rel_branch_seq;

    localparam logic [2:0] CYC_NONE = 3'd0;
    localparam logic [2:0] CYC_INT  = 3'd1;
    localparam logic [2:0] CYC_MEM  = 3'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [15:0] ip_in = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic [7:0]  b_in = 8'h00;
    logic        rd_ack = 1'b0;
    logic [7:0]  rd_data = 8'h00;

    logic        rd_req, busy, done, taken, b_we, illegal;
    logic [15:0] rd_addr, ip_out;
    logic [7:0]  b_out;
    logic [2:0]  mcycle_type;

    logic        nd_rd_req, nd_busy, nd_done, nd_taken, nd_b_we, nd_illegal;
    logic [15:0] nd_rd_addr, nd_ip_out;
    logic [7:0]  nd_b_out;
    logic [2:0]  nd_mcycle_type;

    int n_total = 0;
    int n_pass  = 0;

    // Results captured by run_txn
    int          lat, req_cyc, int_cyc, done_cnt, mem_bad;
    logic [15:0] r_ip, r_addr;
    logic        r_taken, r_bwe, r_ill;
    logic [7:0]  r_bout;
    logic        nd_seen, nd_ill, nd_bwe;

    z80_rel_branch_seq #(.ADDR_W(16), .EN_DJNZ(1'b1), .INTERNAL_T(5)) dut (
        .clk(clk), .reset(rst), .start(start), .opcode(opcode), .ip_in(ip_in),
        .f_in(f_in), .b_in(b_in), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .busy(busy), .done(done),
        .ip_out(ip_out), .taken(taken), .b_we(b_we), .b_out(b_out),
        .illegal(illegal), .mcycle_type(mcycle_type)
    );

    z80_rel_branch_seq #(.ADDR_W(16), .EN_DJNZ(1'b0), .INTERNAL_T(5)) dut_nd (
        .clk(clk), .reset(rst), .start(start), .opcode(opcode), .ip_in(ip_in),
        .f_in(f_in), .b_in(b_in), .rd_req(nd_rd_req), .rd_addr(nd_rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .busy(nd_busy), .done(nd_done),
        .ip_out(nd_ip_out), .taken(nd_taken), .b_we(nd_b_we), .b_out(nd_b_out),
        .illegal(nd_illegal), .mcycle_type(nd_mcycle_type)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction. The read is acknowledged after `delay` wait cycles.
    // Flags and B are scrambled after start. hold_start keeps start high
    // (with a bogus opcode) until done.
    task automatic run_txn(input logic [7:0] op, input logic [15:0] ip, input logic [7:0] f,
                           input logic [7:0] b, input logic [7:0] e, input int delay,
                           input bit hold_start);
        int  cyc;
        bit  fin;
        lat = -1; req_cyc = 0; int_cyc = 0; done_cnt = 0; mem_bad = 0;
        r_ip = 16'hxxxx; r_addr = 16'h0000; r_taken = 1'bx; r_bwe = 1'bx;
        r_bout = 8'hxx; r_ill = 1'bx;
        nd_seen = 1'b0; nd_ill = 1'b0; nd_bwe = 1'b0;
        opcode = op; ip_in = ip; f_in = f; b_in = b; start = 1'b1;
        tick();
        if (hold_start) opcode = 8'h00;
        else            start  = 1'b0;
        f_in = ~f;
        b_in = b + 8'd7;
        cyc = 1;
        fin = 1'b0;
        while (!fin && cyc < 40) begin
            rd_ack = 1'b0;
            if (rd_req) begin
                req_cyc++;
                if (req_cyc == 1) r_addr = rd_addr;
                if (mcycle_type !== CYC_MEM) mem_bad++;
                if (req_cyc > delay) begin
                    rd_ack  = 1'b1;
                    rd_data = e;
                end
            end
            if (mcycle_type === CYC_INT) int_cyc++;
            if (nd_done && !nd_seen) begin
                nd_seen = 1'b1;
                nd_ill  = nd_illegal;
                nd_bwe  = nd_b_we;
            end
            if (done) begin
                done_cnt++;
                lat = cyc; r_ip = ip_out; r_taken = taken; r_bwe = b_we;
                r_bout = b_out; r_ill = illegal;
                fin = 1'b1;
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        rd_ack = 1'b0;
        start  = 1'b0;
        repeat (3) begin
            if (done) done_cnt++;
            tick();
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ip_out", ip_out, 0);
        check("rst_flags", {taken, b_we, illegal}, 0);
        check("rst_b_out", b_out, 0);
        check("rst_mcycle", mcycle_type, CYC_NONE);
        rst = 1'b0;
        tick();

        // JR e, e=FE loops back to the opcode
        run_txn(8'h18, 16'h0100, 8'h00, 8'h00, 8'hFE, 0, 1'b0);
        check("jr_lat", lat, 7);
        check("jr_ip", r_ip, 16'h0100);
        check("jr_taken", r_taken, 1);
        check("jr_addr", r_addr, 16'h0101);
        check("jr_req", req_cyc, 1);
        check("jr_int", int_cyc, 5);
        check("jr_bwe_ill", {r_bwe, r_ill}, 0);
        check("jr_mem", mem_bad, 0);
        check("jr_done_cnt", done_cnt, 1);

        // JR NZ with Z=1: not taken
        run_txn(8'h20, 16'h1234, 8'h40, 8'h00, 8'h10, 0, 1'b0);
        check("jrnz_lat", lat, 2);
        check("jrnz_taken", r_taken, 0);
        check("jrnz_ip", r_ip, 16'h1236);
        check("jrnz_int", int_cyc, 0);

        // JR C with C=1 at the top of memory: wraps
        run_txn(8'h38, 16'hFFFF, 8'h01, 8'h00, 8'h7F, 0, 1'b0);
        check("jrc_ip", r_ip, 16'h0080);
        check("jrc_taken", r_taken, 1);
        check("jrc_addr", r_addr, 16'h0000);

        // JR NC with C=0, most negative displacement
        run_txn(8'h30, 16'h0010, 8'h00, 8'h00, 8'h80, 0, 1'b0);
        check("jrnc_ip", r_ip, 16'hFF92);
        check("jrnc_taken", r_taken, 1);

        // JR NC with C=1: not taken
        run_txn(8'h30, 16'h0010, 8'h01, 8'h00, 8'h80, 0, 1'b0);
        check("jrnc_nt_ip", r_ip, 16'h0012);
        check("jrnc_nt_taken", r_taken, 0);

        // DJNZ reaching zero: falls through; EN_DJNZ=0 build flags it illegal
        run_txn(8'h10, 16'h2000, 8'h00, 8'h01, 8'h05, 0, 1'b0);
        check("djnz1_lat", lat, 3);
        check("djnz1_bout", r_bout, 8'h00);
        check("djnz1_bwe", r_bwe, 1);
        check("djnz1_taken", r_taken, 0);
        check("djnz1_ip", r_ip, 16'h2002);
        check("djnz1_int", int_cyc, 1);
        check("nd_done", nd_seen, 1);
        check("nd_illegal", nd_ill, 1);
        check("nd_bwe", nd_bwe, 0);

        // DJNZ from 00: wraps to FF, taken
        run_txn(8'h10, 16'h3000, 8'h00, 8'h00, 8'hFE, 0, 1'b0);
        check("djnz0_lat", lat, 8);
        check("djnz0_bout", r_bout, 8'hFF);
        check("djnz0_bwe", r_bwe, 1);
        check("djnz0_taken", r_taken, 1);
        check("djnz0_ip", r_ip, 16'h3000);
        check("djnz0_int", int_cyc, 6);

        // JR Z taken, three wait states, start held high throughout
        run_txn(8'h28, 16'h0500, 8'h40, 8'h00, 8'h03, 3, 1'b1);
        check("wait_req", req_cyc, 4);
        check("wait_lat", lat, 10);
        check("wait_done_cnt", done_cnt, 1);
        check("wait_ip", r_ip, 16'h0505);
        check("wait_taken", r_taken, 1);

        // Illegal opcode 00
        run_txn(8'h00, 16'h4000, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("ill_lat", lat, 1);
        check("ill_flag", r_ill, 1);
        check("ill_ip", r_ip, 16'h4001);
        check("ill_req", req_cyc, 0);
        check("ill_taken_bwe", {r_taken, r_bwe}, 0);

        // Reset during READ drops rd_req without waiting for a clock edge
        opcode = 8'h18; ip_in = 16'h0100; start = 1'b1;
        tick();
        start = 1'b0;
        check("rr_req_before", rd_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rr_req_async", rd_req, 0);
        check("rr_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Reset during INTERNAL
        opcode = 8'h18; ip_in = 16'h0100; start = 1'b1;
        tick();
        start = 1'b0; rd_ack = 1'b1; rd_data = 8'h02;
        tick();
        rd_ack = 1'b0;
        tick();
        check("ri_in_internal", mcycle_type, CYC_INT);
        #2 rst = 1'b1;
        #1;
        check("ri_busy", busy, 0);
        check("ri_mcycle", mcycle_type, CYC_NONE);
        check("ri_outs", {rd_req, done, taken, b_we, illegal}, 0);
        check("ri_ip_out", ip_out, 0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            if (done) done_cnt++;
            tick();
        end
        check("ri_no_done", done_cnt, 0);
        check("ri_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
